// File: rtl/svo_tmds_multi.sv
// svo_tmds_multi: NCH-lane TMDS/TERC4 encoder with per-lane DC balance and fixed 2+PIPE_EXTRA latency
module svo_tmds_multi #(
    parameter int NCH        = 3,
    parameter int PIPE_EXTRA = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        mode,
    input  logic [8*NCH-1:0]  din,
    input  logic [2*NCH-1:0]  ctrl,
    input  logic [4*NCH-1:0]  terc,
    output logic [10*NCH-1:0] dout
);
    localparam logic [2:0] M_VIDEO = 3'd1, M_VGB = 3'd2, M_TERC = 3'd3, M_DGB = 3'd4;

    function automatic logic [9:0] terc4(input logic [3:0] t);
        case (t)
            4'h0: terc4 = 10'h29C;
            4'h1: terc4 = 10'h263;
            4'h2: terc4 = 10'h2E4;
            4'h3: terc4 = 10'h2E2;
            4'h4: terc4 = 10'h171;
            4'h5: terc4 = 10'h11E;
            4'h6: terc4 = 10'h18E;
            4'h7: terc4 = 10'h13C;
            4'h8: terc4 = 10'h2CC;
            4'h9: terc4 = 10'h139;
            4'hA: terc4 = 10'h19C;
            4'hB: terc4 = 10'h2C6;
            4'hC: terc4 = 10'h28E;
            4'hD: terc4 = 10'h271;
            4'hE: terc4 = 10'h163;
            default: terc4 = 10'h2C3;
        endcase
    endfunction

    logic [2:0]        mode_q;
    logic              v1_q;
    logic [10*NCH-1:0] sym_flat;

    // v1_q keeps the reset-cleared stage 1 from emitting a CTRL symbol
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= '0;
            v1_q   <= 1'b0;
        end else begin
            mode_q <= mode;
            v1_q   <= 1'b1;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        localparam int ROLE = i % 3;
        logic [7:0]        d;
        logic [8:0]        qm_d, qm_q;
        logic [3:0]        nd, n1_d, n1_q;
        logic [1:0]        ctrl_q;
        logic [3:0]        terc_q;
        logic              use_xnor, q8, case1, case2;
        logic signed [4:0] cnt_d, cnt_q;
        logic signed [5:0] c6, d6, nxt;
        logic [9:0]        vid, sym, sym_d, sym_q;

        assign d  = din[8*i +: 8];
        assign q8 = qm_q[8];

        always_comb begin
            nd = '0;
            for (int k = 0; k < 8; k++) nd = nd + {3'b0, d[k]};
            use_xnor = nd > 4'd4 || (nd == 4'd4 && !d[0]);
            qm_d     = {~use_xnor, 8'b0};
            qm_d[0]  = d[0];
            for (int k = 1; k < 8; k++) qm_d[k] = qm_d[k-1] ^ d[k] ^ use_xnor;
            n1_d = '0;
            for (int k = 0; k < 8; k++) n1_d = n1_d + {3'b0, qm_d[k]};
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                qm_q   <= '0;
                n1_q   <= '0;
                ctrl_q <= '0;
                terc_q <= '0;
            end else begin
                qm_q   <= qm_d;
                n1_q   <= n1_d;
                ctrl_q <= ctrl[2*i +: 2];
                terc_q <= terc[4*i +: 4];
            end
        end

        // disparity arithmetic at 6 bits, same-sign test on the sign bits
        always_comb begin
            c6    = {cnt_q[4], cnt_q};
            d6    = $signed({1'b0, n1_q, 1'b0}) - 6'sd8;
            case1 = cnt_q == 5'sd0 || d6 == 6'sd0;
            case2 = !case1 && (c6[5] == d6[5]);
            vid   = case1 ? {~q8, q8, q8 ? qm_q[7:0] : ~qm_q[7:0]} :
                    case2 ? {1'b1, q8, ~qm_q[7:0]} : {1'b0, q8, qm_q[7:0]};
            nxt   = case1 ? (q8 ? c6 + d6 : c6 - d6) :
                    case2 ? c6 + $signed({4'b0, q8, 1'b0}) - d6 :
                            c6 - $signed({4'b0, ~q8, 1'b0}) + d6;
            sym   = mode_q == M_VIDEO ? vid :
                    mode_q == M_VGB   ? (ROLE == 1 ? 10'h133 : 10'h2CC) :
                    mode_q == M_TERC  ? terc4(terc_q) :
                    mode_q == M_DGB   ? (ROLE == 0 ? terc4(terc_q) : 10'h133) :
                    ctrl_q == 2'd0    ? 10'h354 :
                    ctrl_q == 2'd1    ? 10'h0AB :
                    ctrl_q == 2'd2    ? 10'h154 : 10'h2AB;
            sym_d = v1_q ? sym : '0;
            cnt_d = mode_q == M_VIDEO ? nxt[4:0] : 5'sd0;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                sym_q <= '0;
                cnt_q <= '0;
            end else begin
                sym_q <= sym_d;
                cnt_q <= cnt_d;
            end
        end

        assign sym_flat[10*i +: 10] = sym_q;
    end

    if (PIPE_EXTRA == 0) begin : g_nopipe
        assign dout = sym_flat;
    end else begin : g_pipe
        logic [10*NCH-1:0] pipe_q [PIPE_EXTRA];
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int j = 0; j < PIPE_EXTRA; j++) pipe_q[j] <= '0;
            end else begin
                pipe_q[0] <= sym_flat;
                for (int j = 1; j < PIPE_EXTRA; j++) pipe_q[j] <= pipe_q[j-1];
            end
        end
        assign dout = pipe_q[PIPE_EXTRA-1];
    end
endmodule

// File: tb/tb_svo_tmds_multi.sv
// tb_svo_tmds_multi: directed and random checks of svo_tmds_multi across lane counts and pipeline depths
module tb_svo_tmds_multi;
    localparam logic [2:0] CTRL = 3'd0, VIDEO = 3'd1, VGB = 3'd2, TERC = 3'd3, DGB = 3'd4;
    localparam int PE [5] = '{0, 2, 1, 3, 4};

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  mode;
    logic [31:0] din;
    logic [7:0]  ctrl;
    logic [15:0] terc;
    logic [39:0] dout0;
    logic [29:0] dout1, dout3;
    logic [9:0]  dout2, dout4;
    logic [9:0]  l0 [5];
    logic [9:0]  tt [16];
    logic [9:0]  ctab [4];
    int          ref_cnt [4];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    svo_tmds_multi #(.NCH(4), .PIPE_EXTRA(0)) u0 (.clk(clk), .reset(reset), .mode(mode), .din(din),
        .ctrl(ctrl), .terc(terc), .dout(dout0));
    svo_tmds_multi #(.NCH(3), .PIPE_EXTRA(2)) u1 (.clk(clk), .reset(reset), .mode(mode), .din(din[23:0]),
        .ctrl(ctrl[5:0]), .terc(terc[11:0]), .dout(dout1));
    svo_tmds_multi #(.NCH(1), .PIPE_EXTRA(1)) u2 (.clk(clk), .reset(reset), .mode(mode), .din(din[7:0]),
        .ctrl(ctrl[1:0]), .terc(terc[3:0]), .dout(dout2));
    svo_tmds_multi #(.NCH(3), .PIPE_EXTRA(3)) u3 (.clk(clk), .reset(reset), .mode(mode), .din(din[23:0]),
        .ctrl(ctrl[5:0]), .terc(terc[11:0]), .dout(dout3));
    svo_tmds_multi #(.NCH(1), .PIPE_EXTRA(4)) u4 (.clk(clk), .reset(reset), .mode(mode), .din(din[7:0]),
        .ctrl(ctrl[1:0]), .terc(terc[3:0]), .dout(dout4));

    assign l0[0] = dout0[9:0];
    assign l0[1] = dout1[9:0];
    assign l0[2] = dout2;
    assign l0[3] = dout3[9:0];
    assign l0[4] = dout4;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] m, input logic [7:0] d, input logic [1:0] c, input logic [3:0] t);
        mode = m;
        din  = {4{d}};
        ctrl = {4{c}};
        terc = {4{t}};
    endtask

    // Textbook DVI encoder with unbounded integer disparity
    function automatic logic [9:0] ref_video(input int l, input logic [7:0] d);
        int         n1, diff;
        logic       x;
        logic [8:0] q;
        logic [9:0] s;
        n1   = $countones(d);
        x    = (n1 > 4) || (n1 == 4 && !d[0]);
        q[0] = d[0];
        for (int k = 1; k < 8; k++) q[k] = x ? ~(q[k-1] ^ d[k]) : (q[k-1] ^ d[k]);
        q[8] = ~x;
        diff = 2 * $countones(q[7:0]) - 8;
        if (ref_cnt[l] == 0 || diff == 0) begin
            s = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
            ref_cnt[l] += q[8] ? diff : -diff;
        end else if ((ref_cnt[l] > 0 && diff > 0) || (ref_cnt[l] < 0 && diff < 0)) begin
            s = {1'b1, q[8], ~q[7:0]};
            ref_cnt[l] = ref_cnt[l] + (q[8] ? 2 : 0) - diff;
        end else begin
            s = {1'b0, q[8], q[7:0]};
            ref_cnt[l] = ref_cnt[l] - (q[8] ? 0 : 2) + diff;
        end
        return s;
    endfunction

    function automatic logic [7:0] dec(input logic [9:0] s);
        logic [7:0] b, o;
        b    = s[9] ? ~s[7:0] : s[7:0];
        o[0] = b[0];
        for (int k = 1; k < 8; k++) o[k] = s[8] ? (b[k] ^ b[k-1]) : ~(b[k] ^ b[k-1]);
        return o;
    endfunction

    task automatic test_reset;
        checks++; if (dout0 !== 40'h0) begin errors++; $display("FAIL reset u0: got %h want 0", dout0); end
        checks++; if (dout1 !== 30'h0) begin errors++; $display("FAIL reset u1: got %h want 0", dout1); end
        checks++; if (dout2 !== 10'h0) begin errors++; $display("FAIL reset u2: got %h want 0", dout2); end
        checks++; if (dout3 !== 30'h0) begin errors++; $display("FAIL reset u3: got %h want 0", dout3); end
        checks++; if (dout4 !== 10'h0) begin errors++; $display("FAIL reset u4: got %h want 0", dout4); end
    endtask

    task automatic test_video_zeros;
        logic [9:0] exp [7];
        exp = '{10'h354, 10'h354, 10'h354, 10'h354, 10'h100, 10'h3FF, 10'h100};
        for (int i = 0; i <= 7; i++) begin
            if (i >= 4 && i < 7) drive(VIDEO, 8'h00, 2'd0, 4'd0);
            else drive(CTRL, 8'h00, 2'd0, 4'd0);
            step();
            if (i >= 1) begin
                checks++;
                if (dout0 !== {4{exp[i-1]}}) begin
                    errors++; $display("FAIL video_zeros[%0d]: got %h want %h", i - 1, dout0, {4{exp[i-1]}});
                end
            end
        end
    endtask

    task automatic test_video_ones;
        logic [9:0] exp [3];
        exp = '{10'h354, 10'h200, 10'h0FF};
        for (int i = 0; i <= 3; i++) begin
            if (i == 1 || i == 2) drive(VIDEO, 8'hFF, 2'd0, 4'd0);
            else drive(CTRL, 8'h00, 2'd0, 4'd0);
            step();
            if (i >= 1) begin
                checks++;
                if (dout0 !== {4{exp[i-1]}}) begin
                    errors++; $display("FAIL video_ones[%0d]: got %h want %h", i - 1, dout0, {4{exp[i-1]}});
                end
            end
        end
    endtask

    task automatic test_mode_switch;
        logic [9:0] exp [5];
        exp = '{10'h100, 10'h0AB, 10'h100, 10'h2AB, 10'h100};
        for (int i = 0; i <= 5; i++) begin
            case (i)
                0, 2, 4: drive(VIDEO, 8'h00, 2'd0, 4'd0);
                1:       drive(CTRL, 8'h00, 2'd1, 4'd0);
                3:       drive(3'd6, 8'h00, 2'd3, 4'd0);
                default: drive(CTRL, 8'h00, 2'd0, 4'd0);
            endcase
            step();
            if (i >= 1) begin
                checks++;
                if (dout0 !== {4{exp[i-1]}}) begin
                    errors++; $display("FAIL mode_switch[%0d]: got %h want %h", i - 1, dout0, {4{exp[i-1]}});
                end
            end
        end
    endtask

    task automatic test_data_island;
        logic [39:0] exp [18];
        for (int v = 0; v < 16; v++) exp[v] = {4{tt[v]}};
        exp[16] = {tt[10], 10'h133, 10'h133, 10'h28E};
        exp[17] = {10'h2CC, 10'h2CC, 10'h133, 10'h2CC};
        for (int i = 0; i <= 18; i++) begin
            if (i < 16) drive(TERC, 8'h00, 2'd0, 4'(i));
            else if (i == 16) begin
                drive(DGB, 8'h00, 2'd0, 4'd0);
                terc = 16'hA55C;
            end else if (i == 17) drive(VGB, 8'h00, 2'd0, 4'd0);
            else drive(CTRL, 8'h00, 2'd0, 4'd0);
            step();
            if (i >= 1) begin
                checks++;
                if (dout0 !== exp[i-1]) begin
                    errors++; $display("FAIL data_island[%0d]: got %h want %h", i - 1, dout0, exp[i-1]);
                end
            end
        end
    endtask

    task automatic test_random;
        logic [7:0] cur_d [4], prev_d [4];
        logic [9:0] cur_e [4], prev_e [4];
        for (int l = 0; l < 4; l++) ref_cnt[l] = 0;
        for (int i = 0; i <= 10000; i++) begin
            if (i < 10000) begin
                mode = VIDEO;
                for (int l = 0; l < 4; l++) begin
                    cur_d[l] = 8'($urandom);
                    cur_e[l] = ref_video(l, cur_d[l]);
                    din[8*l +: 8] = cur_d[l];
                end
            end else drive(CTRL, 8'h00, 2'd0, 4'd0);
            step();
            if (i >= 1) begin
                for (int l = 0; l < 4; l++) begin
                    checks++;
                    if (dout0[10*l +: 10] !== prev_e[l]) begin
                        errors++; $display("FAIL random[%0d] lane%0d: got %h want %h", i - 1, l, dout0[10*l +: 10], prev_e[l]);
                    end
                    checks++;
                    if (dec(dout0[10*l +: 10]) !== prev_d[l]) begin
                        errors++; $display("FAIL decode[%0d] lane%0d: got %h want %h", i - 1, l, dec(dout0[10*l +: 10]), prev_d[l]);
                    end
                end
            end
            prev_d = cur_d;
            prev_e = cur_e;
        end
    endtask

    task automatic test_reset_latency;
        int         c;
        logic [9:0] expv;
        for (int i = 0; i < 6; i++) begin
            mode = VIDEO;
            din  = $urandom;
            step();
        end
        for (int s = 0; s <= 10; s++) begin
            if (s == 0) begin
                reset = 1'b1;
                mode  = VIDEO;
                din   = $urandom;
            end else begin
                reset = 1'b0;
                drive(CTRL, 8'h00, 2'((s * 3 + 1) % 4), 4'd0);
            end
            step();
            for (int u = 0; u < 5; u++) begin
                c    = s - 1 - PE[u];
                expv = (c >= 1) ? ctab[(c * 3 + 1) % 4] : 10'h000;
                checks++;
                if (l0[u] !== expv) begin
                    errors++; $display("FAIL latency u%0d step%0d: got %h want %h", u, s, l0[u], expv);
                end
            end
        end
        drive(CTRL, 8'h00, 2'd0, 4'd0);
        step();
    endtask

    initial begin
        tt   = '{10'h29C, 10'h263, 10'h2E4, 10'h2E2, 10'h171, 10'h11E, 10'h18E, 10'h13C,
                 10'h2CC, 10'h139, 10'h19C, 10'h2C6, 10'h28E, 10'h271, 10'h163, 10'h2C3};
        ctab = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
        reset = 1'b1;
        drive(VIDEO, 8'h5A, 2'd3, 4'd7);
        step();
        step();
        test_reset();
        reset = 1'b0;
        test_video_zeros();
        test_video_ones();
        test_mode_switch();
        test_data_island();
        test_random();
        test_reset_latency();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
